// File: rtl/step_clock_gen_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// step_clock_gen_if : control/status bundle for step_clock_gen
// Rev 1.0
// ---------------------------------------------------------------------------
interface step_clock_gen_if #(
  parameter int CHANNELS   = 2,
  parameter int CNT_WIDTH  = 26,
  parameter int TCNT_WIDTH = 16
);
  logic [1:0]                    mode;
  logic [CHANNELS*CNT_WIDTH-1:0] div;
  logic                          step_btn;
  logic [CHANNELS-1:0]           tick_en;
  logic [TCNT_WIDTH-1:0]         tick_count;
  logic                          running;
  logic [1:0]                    state;

  modport master (
    output mode, div, step_btn,
    input  tick_en, tick_count, running, state
  );

  modport slave (
    input  mode, div, step_btn,
    output tick_en, tick_count, running, state
  );
endinterface
`default_nettype wire

// File: rtl/step_clock_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// step_clock_gen : per-channel clock-enable ticks with FULL/DIV/STEP/HALT modes
// Rev 1.0
// ---------------------------------------------------------------------------
module step_clock_gen #(
  parameter int CHANNELS    = 2,
  parameter int CNT_WIDTH   = 26,
  parameter int SYNC_STAGES = 2,
  parameter int TCNT_WIDTH  = 16
) (
  input  logic            clk,
  input  logic            reset,
  step_clock_gen_if.slave bus
);

  typedef enum logic [1:0] {
    ST_FULL = 2'b00,
    ST_DIV  = 2'b01,
    ST_STEP = 2'b10,
    ST_HALT = 2'b11
  } state_t;

  state_t                 r_state;
  logic                   r_running;
  logic [CHANNELS-1:0]    r_tick;
  logic [TCNT_WIDTH-1:0]  r_tickCount;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_btnPrev;
  logic                   w_rise;
  logic [CHANNELS-1:0]    w_divTick;
  logic [CHANNELS-1:0]    w_nextTick;

  // The edge register keeps running in every state so a level that is
  // already high on entry to STEP never looks like a fresh press.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync    <= '0;
      r_btnPrev <= 1'b0;
    end else begin
      r_sync    <= {r_sync[SYNC_STAGES-2:0], bus.step_btn};
      r_btnPrev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign w_rise = r_sync[SYNC_STAGES-1] & ~r_btnPrev;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    logic [CNT_WIDTH-1:0] w_div;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic                 w_terminal;

    assign w_div = bus.div[i*CNT_WIDTH +: CNT_WIDTH];
    // ">=" rather than "==" so a divisor shrunk below the count wraps at once.
    assign w_terminal   = (w_div <= CNT_WIDTH'(1)) || (r_cnt >= w_div - CNT_WIDTH'(1));
    assign w_divTick[i] = w_terminal;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_cnt <= '0;
      end else if (r_state == ST_FULL) begin
        r_cnt <= '0;
      end else if (r_state == ST_DIV) begin
        r_cnt <= w_terminal ? '0 : r_cnt + CNT_WIDTH'(1);
      end
    end
  end

  always_comb begin
    w_nextTick = '0;
    case (r_state)
      ST_FULL: w_nextTick = '1;
      ST_DIV:  w_nextTick = w_divTick;
      ST_STEP: w_nextTick = {CHANNELS{w_rise}};
      default: w_nextTick = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_HALT;
      r_running   <= 1'b0;
      r_tick      <= '0;
      r_tickCount <= '0;
    end else begin
      r_state     <= state_t'(bus.mode);
      r_running   <= (bus.mode == ST_FULL) || (bus.mode == ST_DIV);
      r_tick      <= w_nextTick;
      r_tickCount <= r_tickCount + TCNT_WIDTH'(w_nextTick[0]);
    end
  end

  assign bus.tick_en    = r_tick;
  assign bus.tick_count = r_tickCount;
  assign bus.running    = r_running;
  assign bus.state      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_step_clock_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_step_clock_gen : directed + randomized checks against a cycle-level model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_step_clock_gen;
  localparam int CH = 2;
  localparam int CW = 26;
  localparam int SS = 2;
  localparam int TW = 10;
  localparam int TMOD = 1 << TW;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  step_clock_gen_if #(.CHANNELS(CH), .CNT_WIDTH(CW), .TCNT_WIDTH(TW)) bus ();

  step_clock_gen #(
    .CHANNELS(CH), .CNT_WIDTH(CW), .SYNC_STAGES(SS), .TCNT_WIDTH(TW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: state seen by the next edge, cycles elapsed since each
  // channel's last pulse, button history and pulse count.
  logic [1:0]    mState;
  logic [CH-1:0] mTick;
  int            mCount;
  int            elapsed [CH];
  bit            hist [SS+2];
  int            div0, div1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    bus.div = {CW'(div1), CW'(div0)};
  endtask

  task automatic modelReset();
    mState = 2'b11;
    mTick  = '0;
    mCount = 0;
    for (int c = 0; c < CH; c++) elapsed[c] = 0;
    for (int j = 0; j < SS + 2; j++) hist[j] = 1'b0;
  endtask

  task automatic checkAll();
    chk("tick_en",    32'(bus.tick_en),    32'(mTick));
    chk("tick_count", 32'(bus.tick_count), 32'(mCount));
    chk("running",    32'(bus.running),    32'((mState == 2'b00) || (mState == 2'b01)));
    chk("state",      32'(bus.state),      32'(mState));
  endtask

  task automatic clkStep();
    int d;
    @(posedge clk);
    for (int j = SS + 1; j > 0; j--) hist[j] = hist[j-1];
    hist[0] = bus.step_btn;
    mTick = '0;
    case (mState)
      2'b00: begin
        mTick = '1;
        for (int c = 0; c < CH; c++) elapsed[c] = 0;
      end
      2'b01: begin
        for (int c = 0; c < CH; c++) begin
          d = (c == 0) ? div0 : div1;
          elapsed[c]++;
          if (elapsed[c] >= d) begin
            mTick[c]   = 1'b1;
            elapsed[c] = 0;
          end
        end
      end
      2'b10: mTick = (hist[SS] && !hist[SS+1]) ? '1 : '0;
      default: mTick = '0;
    endcase
    if (mTick[0]) mCount = (mCount + 1) % TMOD;
    mState = bus.mode;
    #1;
    checkAll();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int base, pulses, at1, at2, haltPulses, n, guard;

    bus.mode     = 2'b00;
    bus.step_btn = 1'b0;
    div0 = 1; div1 = 1;
    drive();
    modelReset();

    // Reset held five cycles
    repeat (5) @(posedge clk);
    #1;
    checkAll();
    reset = 1'b1;

    // FULL after release: two quiet cycles then all ones
    clkStep();
    chk("full_first", 32'(bus.tick_en), 32'd0);
    clkStep();
    chk("full_second", 32'(bus.tick_en), 32'd3);
    repeat (8) clkStep();

    // DIV 4 / 1 for 40 cycles from a zeroed counter
    bus.mode = 2'b01; div0 = 4; div1 = 1; drive();
    clkStep();
    base = mCount;
    repeat (40) clkStep();
    chk("div4_count40", 32'(bus.tick_count), 32'((base + 10) % TMOD));

    // Shrink divisor 10 -> 3 when the count is at 7
    bus.mode = 2'b00;
    repeat (2) clkStep();
    bus.mode = 2'b01; div0 = 10; div1 = $urandom_range(2, 9); drive();
    clkStep();
    repeat (7) clkStep();
    div0 = 3; drive();
    clkStep();
    chk("shrink_pulse", 32'(bus.tick_en[0]), 32'd1);
    repeat (2) clkStep();
    clkStep();
    chk("shrink_period", 32'(bus.tick_en[0]), 32'd1);

    // STEP: btn high 20, low 5, high 3, low 10
    bus.mode = 2'b10;
    clkStep();
    pulses = 0; at1 = -1; at2 = -1;
    bus.step_btn = 1'b1;
    for (int k = 0; k < 20; k++) begin
      clkStep();
      if (bus.tick_en == 2'b11) begin pulses++; at1 = k; end
    end
    bus.step_btn = 1'b0;
    for (int k = 0; k < 5; k++) begin
      clkStep();
      if (bus.tick_en != 2'b00) pulses++;
    end
    bus.step_btn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      clkStep();
      if (bus.tick_en == 2'b11) begin pulses++; at2 = k; end
    end
    bus.step_btn = 1'b0;
    for (int k = 0; k < 10; k++) begin
      clkStep();
      if (bus.tick_en != 2'b00) pulses++;
    end
    chk("step_pulses", 32'(pulses), 32'd2);
    chk("step_lat1",   32'(at1),    32'd2);
    chk("step_lat2",   32'(at2),    32'd2);

    // DIV 5, halt with the count at 2, resume
    bus.mode = 2'b00;
    repeat (2) clkStep();
    bus.mode = 2'b01; div0 = 5; drive();
    clkStep();
    clkStep();
    bus.mode = 2'b11;
    clkStep();
    haltPulses = 0;
    for (int k = 0; k < 50; k++) begin
      clkStep();
      if (bus.tick_en[0]) haltPulses++;
    end
    chk("halt_quiet", 32'(haltPulses), 32'd0);
    bus.mode = 2'b01;
    clkStep();
    clkStep();
    chk("resume_r1", 32'(bus.tick_en[0]), 32'd0);
    clkStep();
    chk("resume_r2", 32'(bus.tick_en[0]), 32'd0);
    clkStep();
    chk("resume_r3", 32'(bus.tick_en[0]), 32'd1);

    // Randomized mode / divisor / button mix
    for (int seg = 0; seg < 40; seg++) begin
      bus.mode = 2'($urandom_range(0, 3));
      div0 = $urandom_range(0, 7);
      div1 = $urandom_range(0, 7);
      drive();
      n = $urandom_range(2, 12);
      for (int k = 0; k < n; k++) begin
        if ($urandom_range(0, 3) == 0) bus.step_btn = ~bus.step_btn;
        clkStep();
      end
    end
    bus.step_btn = 1'b0;

    // tick_count wrap
    bus.mode = 2'b00;
    guard = 0;
    while (mCount != TMOD - 1 && guard < 1100) begin
      clkStep();
      guard++;
    end
    chk("wrap_reach", 32'(bus.tick_count), 32'(TMOD - 1));
    clkStep();
    chk("wrap_zero", 32'(bus.tick_count), 32'd0);

    // Asynchronous reset in the middle of a DIV period
    repeat (2) clkStep();
    bus.mode = 2'b01; div0 = $urandom_range(5, 9); div1 = $urandom_range(2, 4); drive();
    repeat (3) clkStep();
    #2;
    reset = 1'b0;
    #1;
    modelReset();
    chk("areset_tick",  32'(bus.tick_en),    32'd0);
    chk("areset_count", 32'(bus.tick_count), 32'd0);
    chk("areset_state", 32'(bus.state),      32'd3);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (25) clkStep();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
